// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: NB legality, row offsets, byte placement, and the
// occupancy encoding of the output skid buffer.
package aes_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael ShiftRows offsets; only the 256-bit block widens rows 2 and 3.
  function automatic int row_shift(input int nb, input int r);
    int s;
    case (r)
      0:       s = 0;
      1:       s = 1;
      2:       s = (nb == 8) ? 3 : 2;
      default: s = (nb == 8) ? 4 : 3;
    endcase
    return s;
  endfunction

  // LSB position of byte (r,c); byte (0,0) is the most significant byte.
  function automatic int byte_lsb(input int nb, input int r, input int c);
    return 32*nb - 8 - 8*(4*c + r);
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready stream bundle for shift_rows_pipe; the pipe is the slave side.
interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  localparam int W = 32*NB;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_state;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_state;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_state, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_state, out_tag, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_state, out_tag, busy
  );

endinterface

// File: rtl/shift_rows_nb.sv
// Combinational Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns.
module shift_rows_nb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state,
  input  logic             inv,
  output logic [32*NB-1:0] result
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_nb: NB must be 4, 6 or 8");
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S     = row_shift(NB, r);
      localparam int FWD_C = (c + S) % NB;
      localparam int INV_C = (c - S + NB) % NB;

      assign result[byte_lsb(NB, r, c) +: 8] =
        inv ? state[byte_lsb(NB, r, INV_C) +: 8]
            : state[byte_lsb(NB, r, FWD_C) +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage with latency 1, followed by a 2-entry skid buffer that keeps
// in_ready free of any combinational dependence on out_ready.
//
// state     | meaning
// OCC_EMPTY | nothing held, out_valid = 0
// OCC_ONE   | output register holds a block, skid empty
// OCC_FULL  | output register and skid register both hold blocks, in_ready = 0
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  shift_rows_pipe_if.slave  bus
);

  localparam int W = 32*NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0]     shifted;
  occ_e             occ;
  logic             out_valid_q;
  logic             skid_full_q;
  logic             ready_q;
  logic [W-1:0]     out_state_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [W-1:0]     skid_state_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             out_load;
  logic             skid_load;

  shift_rows_nb #(.NB(NB)) u_shift (
    .state  (bus.in_state),
    .inv    (bus.in_inv),
    .result (shifted)
  );

  // ready_q is preset during reset so the port is already high on the first
  // cycle after release; gating with rst keeps it low while reset is held.
  assign in_ready = ready_q & ~rst;
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    out_load  = 1'b0;
    skid_load = 1'b0;
    unique case (occ)
      OCC_EMPTY: out_load = in_fire;
      OCC_ONE: begin
        out_load  = in_fire & out_fire;
        skid_load = in_fire & ~out_fire;
      end
      OCC_FULL:  out_load = out_fire;
      default: begin
        out_load  = 1'b0;
        skid_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      unique case (occ)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ         <= OCC_ONE;
            out_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && !out_fire) begin
            occ         <= OCC_FULL;
            skid_full_q <= 1'b1;
            ready_q     <= 1'b0;
          end else if (!in_fire && out_fire) begin
            occ         <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            occ         <= OCC_ONE;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          occ         <= OCC_EMPTY;
          out_valid_q <= 1'b0;
          skid_full_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // Payload registers carry no reset; their contents are qualified by the flags.
  always_ff @(posedge clk) begin
    if (out_load) begin
      out_state_q <= (occ == OCC_FULL) ? skid_state_q : shifted;
      out_tag_q   <= (occ == OCC_FULL) ? skid_tag_q   : bus.in_tag;
    end
    if (skid_load) begin
      skid_state_q <= shifted;
      skid_tag_q   <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.busy      = out_valid_q | skid_full_q;

endmodule
